// File: rtl/multicycle_control_unit.sv
// Moore control FSM sequencing one RV32I instruction through the multicycle datapath.
// Latency: 3-6 cycles per instruction plus one cycle per memory wait state.
// Backpressure: holds in IF, MEM_RD and MEM_WR until mem_ready. Outputs are forced to 0 while reset is low.
module multicycle_control_unit #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctrl_op,
    output logic       pc_write,
    output logic       pc_source,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       is_ecall,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_WB_ALU   = 4'd4,
        S_EX_ADDR  = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_EX_BR    = 4'd9,
        S_PC4      = 4'd10,
        S_EX_JAL   = 4'd11,
        S_EX_JALR  = 4'd12,
        S_EX_ECALL = 4'd13
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = S_IF;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        mdr_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl_op = 2'b00;
        pc_write    = 1'b0;
        pc_source   = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 2'b00;
        is_ecall    = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                state_d  = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // ALUOut captures PC+imm here so branch/JAL targets are ready later
                alu_src_b = 2'b10;
                case (opcode)
                    7'b0110011: state_d = S_EX_R;
                    7'b0010011: state_d = S_EX_I;
                    7'b0000011,
                    7'b0100011: state_d = S_EX_ADDR;
                    7'b1100011: state_d = S_EX_BR;
                    7'b1101111: state_d = S_EX_JAL;
                    7'b1100111: state_d = S_EX_JALR;
                    7'b1110011: state_d = S_EX_ECALL;
                    default:    state_d = S_PC4;
                endcase
            end
            S_EX_R: begin
                alu_src_a   = 1'b1;
                alu_ctrl_op = 2'b10;
                state_d     = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_ctrl_op = 2'b11;
                state_d     = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_PC4;
            end
            S_EX_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // opcode bit 5 separates store (0100011) from load (0000011)
                state_d   = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                mdr_write = mem_ready;
                state_d   = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                state_d   = S_PC4;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? S_PC4 : S_MEM_WR;
            end
            S_EX_BR: begin
                alu_src_a   = 1'b1;
                alu_ctrl_op = 2'b11;
                pc_source   = 1'b1;
                pc_write    = bcond;
                retire      = bcond;
                state_d     = bcond ? S_IF : S_PC4;
            end
            S_PC4: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = S_IF;
            end
            S_EX_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_source = 1'b1;
                retire    = 1'b1;
                state_d   = S_IF;
            end
            S_EX_JALR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                retire    = 1'b1;
                state_d   = S_IF;
            end
            S_EX_ECALL: begin
                is_ecall = 1'b1;
                state_d  = S_PC4;
            end
            default: state_d = S_IF;
        endcase

        // Strobes must not reach the datapath or memory while reset is held
        if (!reset) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            i_or_d      = 1'b0;
            ir_write    = 1'b0;
            mdr_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_ctrl_op = 2'b00;
            pc_write    = 1'b0;
            pc_source   = 1'b0;
            reg_write   = 1'b0;
            wb_sel      = 2'b00;
            is_ecall    = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: a per-instruction reference model builds the
// expected cycle-by-cycle state trace and outputs, including memory wait states and reset cases.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_src_a;
    logic [1:0] alu_src_b, alu_ctrl_op;
    logic       pc_write, pc_source, reg_write;
    logic [1:0] wb_sel;
    logic       is_ecall, retire;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int st;
        bit mr;
        bit bc;
    } cyc_t;

    multicycle_control_unit #(.RESET_STATE(4'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .bcond       (bcond),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .mdr_write   (mdr_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_ctrl_op (alu_ctrl_op),
        .pc_write    (pc_write),
        .pc_source   (pc_source),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .is_ecall    (is_ecall),
        .retire      (retire),
        .state       (state)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_out;
    assign dut_out = {mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_src_a, alu_src_b,
                      alu_ctrl_op, pc_write, pc_source, reg_write, wb_sel, is_ecall, retire};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word per state, written straight from the state descriptions
    function automatic logic [16:0] exp_out(input int st, input bit mr, input bit bc);
        logic mrd = 0, mw = 0, iod = 0, ird = 0, mdr = 0, srca = 0;
        logic [1:0] srcb = 0, aop = 0, wb = 0;
        logic pw = 0, psrc = 0, rw = 0, ec = 0, ret = 0;
        case (st)
            0:  begin mrd = 1; ird = mr; end
            1:  begin srcb = 2; end
            2:  begin srca = 1; aop = 2; end
            3:  begin srca = 1; srcb = 2; aop = 3; end
            4:  begin rw = 1; end
            5:  begin srca = 1; srcb = 2; end
            6:  begin mrd = 1; iod = 1; mdr = mr; end
            7:  begin rw = 1; wb = 1; end
            8:  begin mw = 1; iod = 1; end
            9:  begin srca = 1; aop = 3; psrc = 1; pw = bc; ret = bc; end
            10: begin srcb = 1; pw = 1; ret = 1; end
            11: begin rw = 1; wb = 2; pw = 1; psrc = 1; ret = 1; end
            12: begin srca = 1; srcb = 2; pw = 1; rw = 1; wb = 2; ret = 1; end
            13: begin ec = 1; end
            default: ;
        endcase
        return {mrd, mw, iod, ird, mdr, srca, srcb, aop, pw, psrc, rw, wb, ec, ret};
    endfunction

    // Zero-wait latency from IF entry to retire
    function automatic int base_latency(input logic [6:0] opc, input bit bc);
        case (opc)
            7'b0110011, 7'b0010011, 7'b0100011: return 5;
            7'b0000011:                         return 6;
            7'b1100011:                         return bc ? 3 : 4;
            7'b1101111, 7'b1100111:             return 3;
            7'b1110011:                         return 4;
            default:                            return 3;
        endcase
    endfunction

    task automatic push_wait(inout cyc_t q[$], input int st, input int waits);
        for (int w = 0; w < waits; w++) q.push_back('{st, 1'b0, 1'b0});
        q.push_back('{st, 1'b1, 1'b0});
    endtask

    task automatic run_instr(input logic [6:0] opc, input bit bc, input int if_wait,
                             input int mem_wait);
        cyc_t q[$];
        int   n_ret = 0;
        int   n_pcw = 0;
        int   lat   = 0;
        int   cyc   = 0;
        push_wait(q, 0, if_wait);
        q.push_back('{1, 1'b0, 1'b0});
        case (opc)
            7'b0110011: begin q.push_back('{2, 0, 0}); q.push_back('{4, 0, 0}); end
            7'b0010011: begin q.push_back('{3, 0, 0}); q.push_back('{4, 0, 0}); end
            7'b0000011: begin
                q.push_back('{5, 0, 0});
                push_wait(q, 6, mem_wait);
                q.push_back('{7, 0, 0});
            end
            7'b0100011: begin q.push_back('{5, 0, 0}); push_wait(q, 8, mem_wait); end
            7'b1100011: q.push_back('{9, 1'b0, bc});
            7'b1101111: q.push_back('{11, 0, 0});
            7'b1100111: q.push_back('{12, 0, 0});
            7'b1110011: q.push_back('{13, 0, 0});
            default: ;
        endcase
        if (!(opc == 7'b1100011 && bc) && opc != 7'b1101111 && opc != 7'b1100111)
            q.push_back('{10, 0, 0});

        foreach (q[i]) begin
            @(negedge clk);
            reset     = 1'b1;
            opcode    = (q[i].st == 0) ? 7'($urandom) : opc;
            mem_ready = (q[i].st == 0 || q[i].st == 6 || q[i].st == 8) ? q[i].mr
                                                                         : 1'($urandom);
            bcond     = (q[i].st == 9) ? q[i].bc : 1'($urandom);
            #1;
            cyc++;
            check("state", 32'(state), 32'(q[i].st));
            check("outputs", 32'(dut_out), 32'(exp_out(q[i].st, mem_ready, bcond)));
            if (retire === 1'b1) begin
                n_ret++;
                if (lat == 0) lat = cyc;
            end
            if (pc_write === 1'b1) n_pcw++;
        end
        check("retire_count", 32'(n_ret), 32'd1);
        check("pc_write_count", 32'(n_pcw), 32'd1);
        check("latency", 32'(lat), 32'(base_latency(opc, bc) + if_wait +
              ((opc == 7'b0000011 || opc == 7'b0100011) ? mem_wait : 0)));
    endtask

    logic [6:0] opc_tab [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 7'b0110011;
        bcond     = 1'b0;

        // Reset held for 3 cycles with memory ready
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_state", 32'(state), 32'd0);
            check("rst_outputs", 32'(dut_out), 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;

        // Directed scenarios
        run_instr(7'b0110011, 1'b0, 0, 0);
        run_instr(7'b0000011, 1'b0, 0, 2);
        run_instr(7'b1100011, 1'b1, 0, 0);
        run_instr(7'b1100011, 1'b0, 0, 0);
        run_instr(7'b1100111, 1'b0, 0, 0);
        run_instr(7'b1110011, 1'b0, 0, 0);
        run_instr(7'b0000000, 1'b0, 0, 0);
        run_instr(7'b1101111, 1'b0, 1, 0);
        run_instr(7'b0100011, 1'b0, 2, 3);

        // Reset during a stalled store
        @(negedge clk); opcode = 7'($urandom); mem_ready = 1'b1; #1;
        check("mr_if", 32'(state), 32'd0);
        @(negedge clk); opcode = 7'b0100011; #1;
        check("mr_id", 32'(state), 32'd1);
        @(negedge clk); #1;
        check("mr_addr", 32'(state), 32'd5);
        @(negedge clk); mem_ready = 1'b0; #1;
        check("mr_memwr", 32'(state), 32'd8);
        check("mr_write_before", 32'(mem_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mr_write_dropped", 32'(mem_write), 32'd0);
        check("mr_state_async", 32'(state), 32'd0);
        check("mr_outputs", 32'(dut_out), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = 1'($urandom); #1;
            check("mr_hold_state", 32'(state), 32'd0);
            check("mr_hold_outputs", 32'(dut_out), 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("mr_release_state", 32'(state), 32'd0);
        check("mr_release_nowrite", 32'(mem_write), 32'd0);
        check("mr_release_outputs", 32'(dut_out), 32'(exp_out(0, 1'b0, 1'b0)));

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [6:0] opc;
            opc = ($urandom_range(0, 4) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 7)];
            run_instr(opc, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
